// File: rtl/vip_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vip_pkt_pkg
// Description : Shared VIP packet constants, FSM state type and beat-count
//               helper for the control packet inserter.
// Revision    : 1.0 - initial release
// ============================================================================
package vip_pkt_pkg;

    localparam logic [3:0] VIP_TYPE_VIDEO   = 4'h0;
    localparam logic [3:0] VIP_TYPE_CTRL    = 4'hF;
    localparam int         VIP_CTRL_NIBBLES = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CTRL = 2'd1,
        ST_PASS = 2'd2,
        ST_DROP = 2'd3
    } cpi_state_e;

    // One header beat plus enough beats to carry all nibbles.
    function automatic int vip_ctrl_num_beats(input int spb);
        return 1 + (VIP_CTRL_NIBBLES + spb - 1) / spb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vip_ctrl_beat_builder.sv
`default_nettype none
// ============================================================================
// Module      : vip_ctrl_beat_builder
// Description : Combinational map from latched cfg and beat index to the
//               {sop, eop, data} of one VIP control packet beat.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_ctrl_beat_builder
    import vip_pkt_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic [3:0]                                  beat_idx,
    input  logic [15:0]                                 cfg_width,
    input  logic [15:0]                                 cfg_height,
    input  logic [3:0]                                  cfg_interlaced,
    output logic                                        beat_sop,
    output logic                                        beat_eop,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] beat_data
);

    localparam int         NB        = vip_ctrl_num_beats(SYMBOLS_PER_BEAT);
    localparam logic [3:0] LAST_BEAT = 4'(NB - 1);

    // Nibble n sits at bits [4n+3:4n].
    logic [4*VIP_CTRL_NIBBLES-1:0] nib_vec;

    assign nib_vec = {cfg_interlaced,
                      cfg_height[3:0], cfg_height[7:4], cfg_height[11:8], cfg_height[15:12],
                      cfg_width[3:0],  cfg_width[7:4],  cfg_width[11:8],  cfg_width[15:12]};

    assign beat_sop = (beat_idx == 4'd0);
    assign beat_eop = (beat_idx == LAST_BEAT);

    for (genvar s = 0; s < SYMBOLS_PER_BEAT; s++) begin : g_sym
        logic [5:0] nib_idx;
        logic [3:0] nib_val;

        assign nib_idx = 6'(({2'b00, beat_idx} - 6'd1) * 6'(SYMBOLS_PER_BEAT)) + 6'(s);

        always_comb begin
            nib_val = 4'h0;
            for (int n = 0; n < VIP_CTRL_NIBBLES; n++) begin
                if (nib_idx == 6'(n)) begin
                    nib_val = nib_vec[4*n +: 4];
                end
            end
        end

        if (s == 0) begin : g_type
            assign beat_data[BITS_PER_SYMBOL-1:0] =
                BITS_PER_SYMBOL'(beat_sop ? VIP_TYPE_CTRL : nib_val);
        end else begin : g_nib
            assign beat_data[s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] =
                beat_sop ? '0 : BITS_PER_SYMBOL'(nib_val);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vip_control_packet_inserter.sv
`default_nettype none
// ============================================================================
// Module      : vip_control_packet_inserter
// Description : Inserts a generated VIP control packet before every video
//               packet, drops upstream control packets, passes the rest.
//               VIP_CPI_CHANGE_ONLY_EN: insert only when cfg has changed.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_control_packet_inserter
    import vip_pkt_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic                                        dout_sop,
    output logic                                        dout_eop,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    input  logic [15:0]                                 cfg_width,
    input  logic [15:0]                                 cfg_height,
    input  logic [3:0]                                  cfg_interlaced,
    output logic                                        ctrl_sent
);

    localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

    cpi_state_e  state_q,  state_d;
    logic [3:0]  beat_q,   beat_d;
    logic [15:0] width_q,  width_d;
    logic [15:0] height_q, height_d;
    logic [3:0]  ilace_q,  ilace_d;
    logic        hold_q,   hold_d;

    logic          need_ctrl;
    logic          b_sop;
    logic          b_eop;
    logic [DW-1:0] b_data;
    logic [3:0]    din_type;
    logic          ctrl_done;

    assign din_type  = din_data[3:0];
    assign ctrl_done = (state_q == ST_CTRL) && dout_ready && b_eop;

    vip_ctrl_beat_builder #(
        .BITS_PER_SYMBOL  (BITS_PER_SYMBOL),
        .SYMBOLS_PER_BEAT (SYMBOLS_PER_BEAT)
    ) u_builder (
        .beat_idx       (beat_q),
        .cfg_width      (width_q),
        .cfg_height     (height_q),
        .cfg_interlaced (ilace_q),
        .beat_sop       (b_sop),
        .beat_eop       (b_eop),
        .beat_data      (b_data)
    );

`ifdef VIP_CPI_CHANGE_ONLY_EN
    logic        sent_valid_q, sent_valid_d;
    logic [15:0] last_width_q, last_width_d;
    logic [15:0] last_height_q, last_height_d;
    logic [3:0]  last_ilace_q, last_ilace_d;

    assign need_ctrl = !sent_valid_q || (cfg_width != last_width_q) ||
                       (cfg_height != last_height_q) || (cfg_interlaced != last_ilace_q);

    // Last-sent values track what actually went out, so they update on completion.
    always_comb begin
        sent_valid_d  = sent_valid_q;
        last_width_d  = last_width_q;
        last_height_d = last_height_q;
        last_ilace_d  = last_ilace_q;
        if (ctrl_done) begin
            sent_valid_d  = 1'b1;
            last_width_d  = width_q;
            last_height_d = height_q;
            last_ilace_d  = ilace_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_valid_q  <= 1'b0;
            last_width_q  <= 16'h0;
            last_height_q <= 16'h0;
            last_ilace_q  <= 4'h0;
        end else begin
            sent_valid_q  <= sent_valid_d;
            last_width_q  <= last_width_d;
            last_height_q <= last_height_d;
            last_ilace_q  <= last_ilace_d;
        end
    end
`else
    assign need_ctrl = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        width_d    = width_q;
        height_d   = height_q;
        ilace_d    = ilace_q;
        hold_d     = hold_q;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout_sop   = 1'b0;
        dout_eop   = 1'b0;
        dout_data  = '0;
        ctrl_sent  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The sop beat is only inspected here; the next state consumes it.
                if (din_valid) begin
                    if (din_sop) begin
                        if (din_type == VIP_TYPE_VIDEO) begin
                            if (!hold_q && need_ctrl) begin
                                width_d  = cfg_width;
                                height_d = cfg_height;
                                ilace_d  = cfg_interlaced;
                                beat_d   = 4'd0;
                                state_d  = ST_CTRL;
                            end else begin
                                state_d  = ST_PASS;
                            end
                        end else if (din_type == VIP_TYPE_CTRL) begin
                            state_d = ST_DROP;
                        end else begin
                            state_d = ST_PASS;
                        end
                    end else begin
                        din_ready = 1'b1;
                    end
                end
            end

            ST_CTRL: begin
                dout_valid = 1'b1;
                dout_sop   = b_sop;
                dout_eop   = b_eop;
                dout_data  = b_data;
                if (dout_ready) begin
                    if (b_eop) begin
                        ctrl_sent = 1'b1;
                        hold_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end

            ST_PASS: begin
                dout_valid = din_valid;
                dout_sop   = din_sop;
                dout_eop   = din_eop;
                dout_data  = din_data;
                din_ready  = dout_ready;
                if (din_valid && dout_ready && din_eop) begin
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_DROP: begin
                din_ready = 1'b1;
                if (din_valid && din_eop) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= 4'd0;
            width_q  <= 16'h0;
            height_q <= 16'h0;
            ilace_q  <= 4'h0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            width_q  <= width_d;
            height_q <= height_d;
            ilace_q  <= ilace_d;
            hold_q   <= hold_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vip_control_packet_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vip_control_packet_inserter
// Description : Scoreboard bench for the VIP control packet inserter
//               (SPB=3 main instance, SPB=1 secondary instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_control_packet_inserter;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [23:0] data;
        logic        last_ctrl;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_ready, din_valid, din_sop, din_eop;
    logic [23:0] din_data;
    logic        dout_ready, dout_valid, dout_sop, dout_eop;
    logic [23:0] dout_data;
    logic [15:0] cfg_width, cfg_height;
    logic [3:0]  cfg_interlaced;
    logic        ctrl_sent;

    logic        din1_ready, din1_valid, din1_sop, din1_eop;
    logic [7:0]  din1_data;
    logic        dout1_ready, dout1_valid, dout1_sop, dout1_eop;
    logic [7:0]  dout1_data;
    logic [15:0] cfg1_width, cfg1_height;
    logic [3:0]  cfg1_interlaced;
    logic        ctrl1_sent;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    xfer_cnt    = 0;
    int    pulse_cnt   = 0;
    int    ins_cnt     = 0;
    int    bp_mode     = 0;
    int    cyc         = 0;

    logic        m_sent = 1'b0;
    logic [15:0] m_w = '0, m_h = '0;
    logic [3:0]  m_i = '0;

    always #5 clk = ~clk;

    vip_control_packet_inserter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .din_ready(din_ready), .din_valid(din_valid), .din_sop(din_sop),
        .din_eop(din_eop), .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .dout_data(dout_data),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_interlaced(cfg_interlaced), .ctrl_sent(ctrl_sent)
    );

    vip_control_packet_inserter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .din_ready(din1_ready), .din_valid(din1_valid), .din_sop(din1_sop),
        .din_eop(din1_eop), .din_data(din1_data),
        .dout_ready(dout1_ready), .dout_valid(dout1_valid), .dout_sop(dout1_sop),
        .dout_eop(dout1_eop), .dout_data(dout1_data),
        .cfg_width(cfg1_width), .cfg_height(cfg1_height),
        .cfg_interlaced(cfg1_interlaced), .ctrl_sent(ctrl1_sent)
    );

    // Expected control beat k for a given symbols-per-beat, 8-bit symbols.
    function automatic logic [23:0] ctrl_beat(input int k, input int spb,
                                              input logic [15:0] w, input logic [15:0] h,
                                              input logic [3:0] il);
        logic [35:0] nl;
        logic [23:0] r;
        nl = {w, h, il};
        r  = '0;
        if (k == 0) begin
            r[3:0] = 4'hF;
        end else begin
            for (int s = 0; s < spb; s++) begin
                int j;
                j = (k - 1) * spb + s;
                if (j < 9) r[s*8 +: 4] = nl[35 - 4*j -: 4];
            end
        end
        return r;
    endfunction

    function automatic bit need_insert();
`ifdef VIP_CPI_CHANGE_ONLY_EN
        if (m_sent && cfg_width == m_w && cfg_height == m_h && cfg_interlaced == m_i)
            return 1'b0;
`endif
        m_sent = 1'b1;
        m_w    = cfg_width;
        m_h    = cfg_height;
        m_i    = cfg_interlaced;
        return 1'b1;
    endfunction

    function automatic logic [23:0] pkt_data(input logic [3:0] t, input int k, input logic [7:0] tag);
        return {tag, 8'(k * 17), 4'h5, (k == 0) ? t : 4'(k)};
    endfunction

    task automatic push_ctrl();
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{sop: (k == 0), eop: (k == 3),
                              data: ctrl_beat(k, 3, cfg_width, cfg_height, cfg_interlaced),
                              last_ctrl: (k == 3)});
        ins_cnt++;
    endtask

    // Output ready patterns: 0 always ready, 1 repeating 1-0-0-1, 2 random.
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (bp_mode)
                1:       dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor for the SPB=3 instance.
    initial begin
        logic  prev_stall;
        logic [25:0] prev_out;
        beat_t e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    vectors++;
                    if (dout_valid !== 1'b1 || {dout_sop, dout_eop, dout_data} !== prev_out) begin
                        miscompares++;
                        $display("FAIL hold_stable: got v=%b %h, required v=1 %h",
                                 dout_valid, {dout_sop, dout_eop, dout_data}, prev_out);
                    end
                end
                if (dout_valid && dout_ready) begin
                    xfer_cnt++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_beat: got sop=%b eop=%b data=%h, required none",
                                 dout_sop, dout_eop, dout_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (dout_sop !== e.sop || dout_eop !== e.eop || dout_data !== e.data ||
                            ctrl_sent !== e.last_ctrl) begin
                            miscompares++;
                            $display("FAIL out_beat: got sop=%b eop=%b data=%h sent=%b, required sop=%b eop=%b data=%h sent=%b",
                                     dout_sop, dout_eop, dout_data, ctrl_sent,
                                     e.sop, e.eop, e.data, e.last_ctrl);
                        end
                    end
                end else begin
                    vectors++;
                    if (ctrl_sent !== 1'b0) begin
                        miscompares++;
                        $display("FAIL stray_ctrl_sent: got %b, required 0", ctrl_sent);
                    end
                end
                if (ctrl_sent === 1'b1) pulse_cnt++;
                prev_stall = dout_valid && !dout_ready;
                prev_out   = {dout_sop, dout_eop, dout_data};
            end
        end
    end

    task automatic send_beat(input logic s, input logic e, input logic [23:0] d);
        int n;
        n = 0;
        din_valid = 1'b1;
        din_sop   = s;
        din_eop   = e;
        din_data  = d;
        forever begin
            @(negedge clk);
            if (din_ready) break;
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL din_timeout: got din_ready=0 for 200 cycles, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [3:0] t, input int nb, input logic [7:0] tag);
        if (t == 4'h0 && need_insert()) push_ctrl();
        if (t != 4'hF)
            for (int k = 0; k < nb; k++)
                exp_q.push_back('{sop: (k == 0), eop: (k == nb - 1),
                                  data: pkt_data(t, k, tag), last_ctrl: 1'b0});
        for (int k = 0; k < nb; k++)
            send_beat(k == 0, k == nb - 1, pkt_data(t, k, tag));
        din_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int pulses_before, input int ins_before);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
        end
        vectors++;
        if (pulse_cnt - pulses_before != ins_cnt - ins_before) begin
            miscompares++;
            $display("FAIL %s_ctrl_sent: got %0d pulses, required %0d", name,
                     pulse_cnt - pulses_before, ins_cnt - ins_before);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din_sop   = 1'b1;
        din_eop   = 1'b0;
        din_data  = 24'h0;
        din1_valid = 1'b0;
        din1_sop   = 1'b0;
        din1_eop   = 1'b0;
        din1_data  = 8'h0;
        dout1_ready = 1'b1;
        cfg_width = 16'd1920; cfg_height = 16'd1080; cfg_interlaced = 4'h0;
        cfg1_width = 16'd640; cfg1_height = 16'd480; cfg1_interlaced = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b0 || ctrl_sent !== 1'b0 ||
            dout1_valid !== 1'b0 || din1_ready !== 1'b0 || ctrl1_sent !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b r=%b s=%b v1=%b r1=%b s1=%b, required all 0",
                     dout_valid, din_ready, ctrl_sent, dout1_valid, din1_ready, ctrl1_sent);
        end
        din_valid = 1'b0;
        din_sop   = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_video_insert();
        int p0, i0;
        p0 = pulse_cnt; i0 = ins_cnt;
        cfg_width = 16'd1920; cfg_height = 16'd1080; cfg_interlaced = 4'h0;
        send_packet(4'h0, 4, 8'hA1);
        wait_drain("video_insert", p0, i0);
        vectors++;
        if (ins_cnt - i0 != 1) begin
            miscompares++;
            $display("FAIL video_insert_count: got %0d insertions, required 1", ins_cnt - i0);
        end
    endtask

    task automatic test_drop_upstream();
        int p0, i0;
        p0 = pulse_cnt; i0 = ins_cnt;
        send_packet(4'hF, 3, 8'hB2);
        send_packet(4'h0, 2, 8'hB3);
        wait_drain("drop_upstream", p0, i0);
    endtask

    task automatic test_user_packet();
        int p0, i0;
        p0 = pulse_cnt; i0 = ins_cnt;
        send_beat(1'b0, 1'b0, 24'h123450);
        send_beat(1'b0, 1'b1, 24'h678900);
        din_valid = 1'b0;
        send_packet(4'h3, 5, 8'hC4);
        wait_drain("user_packet", p0, i0);
    endtask

    task automatic test_backpressure();
        int p0, i0;
        p0 = pulse_cnt; i0 = ins_cnt;
        cfg_width = 16'd1280; cfg_height = 16'd720; cfg_interlaced = 4'h3;
        bp_mode = 1;
        fork
            send_packet(4'h0, 3, 8'hD5);
            begin
                repeat (4) @(posedge clk);
                #1;
                cfg_width = 16'h0500;
                cfg_interlaced = 4'h7;
            end
        join
        wait_drain("backpressure", p0, i0);
        bp_mode = 0;
    endtask

    task automatic test_back_to_back();
        int p0, i0;
        p0 = pulse_cnt; i0 = ins_cnt;
        bp_mode = 2;
        send_packet(4'h3, 1, 8'hE1);
        send_packet(4'h0, 1, 8'hE2);
        send_packet(4'h0, 3, 8'hE3);
        send_packet(4'hF, 1, 8'hE4);
        send_packet(4'h5, 2, 8'hE5);
        send_packet(4'h0, 2, 8'hE6);
        wait_drain("back_to_back", p0, i0);
        bp_mode = 0;
    endtask

    task automatic test_spb1();
        logic [7:0] exp1 [0:10];
        int idx;
        logic acc_now;
        for (int k = 0; k < 10; k++) begin
            logic [23:0] b;
            b = ctrl_beat(k, 1, cfg1_width, cfg1_height, cfg1_interlaced);
            exp1[k] = b[7:0];
        end
        exp1[10] = 8'h50;
        idx = 0;
        din1_valid = 1'b1;
        din1_sop   = 1'b1;
        din1_eop   = 1'b1;
        din1_data  = 8'h50;
        for (int c = 0; c < 60 && idx < 11; c++) begin
            @(negedge clk);
            if (dout1_valid) begin
                vectors++;
                if (dout1_data !== exp1[idx] || dout1_sop !== (idx == 0 || idx == 10) ||
                    dout1_eop !== (idx >= 9) || ctrl1_sent !== (idx == 9)) begin
                    miscompares++;
                    $display("FAIL spb1_beat%0d: got sop=%b eop=%b data=%h sent=%b, required data=%h",
                             idx, dout1_sop, dout1_eop, dout1_data, ctrl1_sent, exp1[idx]);
                end
                idx++;
            end
            acc_now = din1_valid && din1_ready;
            @(posedge clk);
            #1;
            if (acc_now) din1_valid = 1'b0;
        end
        din1_valid = 1'b0;
        vectors++;
        if (idx != 11) begin
            miscompares++;
            $display("FAIL spb1_count: got %0d beats, required 11", idx);
        end
    endtask

    task automatic test_async_reset();
        int base, n, p0, i0;
        cfg_width = 16'd800; cfg_height = 16'd600; cfg_interlaced = 4'h2;
        if (need_insert()) push_ctrl();
        base = xfer_cnt;
        din_valid = 1'b1;
        din_sop   = 1'b1;
        din_eop   = 1'b0;
        din_data  = pkt_data(4'h0, 0, 8'hF0);
        n = 0;
        while (xfer_cnt < base + 2 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        vectors++;
        if (xfer_cnt < base + 2) begin
            miscompares++;
            $display("FAIL async_reset_setup: got %0d ctrl beats, required 2", xfer_cnt - base);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b0 || ctrl_sent !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got v=%b r=%b s=%b, required 0 0 0",
                     dout_valid, din_ready, ctrl_sent);
        end
        din_valid = 1'b0;
        din_sop   = 1'b0;
        exp_q.delete();
        m_sent = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pulse_cnt; i0 = ins_cnt;
        send_packet(4'h0, 3, 8'hF1);
        send_packet(4'h0, 2, 8'hF2);
        wait_drain("after_reset", p0, i0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_video_insert();
        test_drop_upstream();
        test_user_packet();
        test_backpressure();
        test_back_to_back();
        test_spb1();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
